// File: rtl/timing.sv
// timing: round countdown timer with per-round end pulse and auto-restart
module timing #(
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       gameState,
  input  logic [3:0] roundTime,
  output logic       cout,
  output logic [3:0] secs_left
);
  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] prescaler;
  logic [3:0]    round_len;
  logic          running;
  logic          tick;

  assign tick = prescaler == LAST;

  // idle clears, start latches roundTime, running counts seconds and reloads at round end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      secs_left <= '0;
      round_len <= '0;
      running   <= 1'b0;
      cout      <= 1'b0;
    end else if (!gameState) begin
      prescaler <= '0;
      secs_left <= '0;
      running   <= 1'b0;
      cout      <= 1'b0;
    end else if (!running) begin
      round_len <= roundTime;
      secs_left <= roundTime;
      prescaler <= '0;
      running   <= roundTime != 4'd0;
      cout      <= 1'b0;
    end else begin
      prescaler <= tick ? '0 : prescaler + PW'(1);
      cout      <= tick && secs_left == 4'd1;
      if (tick && secs_left > 4'd1) begin
        secs_left <= secs_left - 4'd1;
      end else if (tick && secs_left == 4'd1) begin
        round_len <= roundTime;
        secs_left <= roundTime;
        running   <= roundTime != 4'd0;
      end
    end
  end

  // the countdown can never exceed the length the round was started with
  always_comb begin
    if (rst_n) assert (secs_left <= round_len);
  end
endmodule

// File: tb/tb_timing.sv
// tb_timing: scoreboard bench for the round timer (TICKS_PER_SEC=4)
module tb_timing;
  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       gameState = 1'b1;
  logic [3:0] roundTime = 4'd5;
  logic       cout;
  logic [3:0] secs_left;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int e0 = 0;
  int exp_q[$];
  logic prev_cout = 1'b0;

  timing #(.TICKS_PER_SEC(T)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .gameState(gameState),
    .roundTime(roundTime),
    .cout(cout),
    .secs_left(secs_left)
  );

  always #5 clk = ~clk;

  // count rising edges so pulse times can be compared against edge indices
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  // scoreboard consumer: each observed pulse must match the next expected edge
  always @(negedge clk) begin
    if (cout) begin
      if (exp_q.size() == 0) chk("spurious_cout", 1, 0);
      else chk("pulse_edge", cyc, exp_q.pop_front());
      if (prev_cout) chk("consecutive_cout", 1, 0);
    end
    prev_cout <= cout;
  end

  task automatic wait_until(input int c);
    int guard = 0;
    while (cyc < c && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc < c) chk("wait_timeout", cyc, c);
  endtask

  task automatic idle(input int n);
    gameState = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic start(input int rt);
    roundTime = 4'(rt);
    gameState = 1'b1;
    e0 = cyc + 1;
  endtask

  task automatic push_pulses(input int first, input int period, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(first + i * period);
  endtask

  initial begin
    // reset held with the game already playing
    repeat (3) begin
      @(negedge clk);
      chk("rst_cout", cout, 0);
      chk("rst_secs", secs_left, 0);
    end
    rst_n = 1'b1;
    e0 = cyc + 1;
    push_pulses(e0 + 20, 20, 3);
    wait_until(e0);
    chk("p1_start_secs", secs_left, 5);
    wait_until(e0 + 4);
    chk("p1_secs_after_tick", secs_left, 4);
    wait_until(e0 + 8);
    chk("p1_secs_after_2tick", secs_left, 3);
    wait_until(e0 + 20);
    chk("p1_reload_secs", secs_left, 5);
    wait_until(e0 + 62);
    chk("p1_queue_drained", exp_q.size(), 0);

    // idle hold
    gameState = 1'b0;
    repeat (100) begin
      @(negedge clk);
      chk("idle_cout", cout, 0);
      chk("idle_secs", secs_left, 0);
    end
    start(3);
    push_pulses(e0 + 12, 12, 2);
    wait_until(e0);
    chk("p2_start_secs", secs_left, 3);
    wait_until(e0 + 26);
    chk("p2_queue_drained", exp_q.size(), 0);

    // abort mid-round
    idle(4);
    start(5);
    wait_until(e0 + 10);
    chk("p3_mid_secs", secs_left, 3);
    gameState = 1'b0;
    @(negedge clk);
    chk("p3_abort_secs", secs_left, 0);
    chk("p3_abort_cout", cout, 0);
    repeat (30) @(negedge clk);
    start(5);
    push_pulses(e0 + 20, 20, 1);
    wait_until(e0);
    chk("p3_restart_secs", secs_left, 5);
    wait_until(e0 + 22);
    chk("p3_queue_drained", exp_q.size(), 0);

    // mid-round roundTime change
    idle(4);
    start(5);
    push_pulses(e0 + 20, 0, 1);
    push_pulses(e0 + 28, 8, 2);
    wait_until(e0 + 6);
    roundTime = 4'd2;
    wait_until(e0 + 12);
    chk("p4_secs_unaffected", secs_left, 2);
    wait_until(e0 + 20);
    chk("p4_reload_secs", secs_left, 2);
    wait_until(e0 + 37);
    chk("p4_queue_drained", exp_q.size(), 0);

    // zero-length rounds never start
    idle(4);
    start(0);
    repeat (50) begin
      @(negedge clk);
      chk("zero_secs", secs_left, 0);
    end
    start(1);
    push_pulses(e0 + 4, 4, 3);
    wait_until(e0);
    chk("p5_start_secs", secs_left, 1);
    wait_until(e0 + 14);
    chk("p5_queue_drained", exp_q.size(), 0);

    // asynchronous reset between edges
    idle(4);
    start(5);
    wait_until(e0 + 7);
    chk("p6_pre_secs", secs_left, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("p6_async_secs", secs_left, 0);
    chk("p6_async_cout", cout, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    e0 = cyc + 1;
    push_pulses(e0 + 20, 20, 1);
    wait_until(e0);
    chk("p6_fresh_secs", secs_left, 5);
    wait_until(e0 + 22);
    chk("p6_queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/timing.md
Name: timing

Overview:
- Round timer for the game controller.
- While the game is in the playing state, it counts down a programmable number of seconds (roundTime) derived from the system clock.
- At the end of each round it emits a one-cycle pulse on cout, then automatically starts the next round.
- cout feeds the round/score sequencer. secs_left feeds the display.

Parameters:
- TICKS_PER_SEC, default 50000000: clk cycles per one-second tick. Must be >= 2. Benches override it to a small value, e.g. 4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- gameState  input  1  1 = round timing enabled (playing), 0 = idle.
- roundTime  input  4  round length in seconds, 0..15.
- cout  output  1  registered one-cycle pulse at end of round.
- secs_left  output  4  registered seconds remaining in the current round.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - prescaler=0, secs_left=0, round_len=0, running=0, cout=0.
  - Asserting reset mid-round aborts the round immediately; no cout is produced.
- Internal state:
  - prescaler: counter of width clog2(TICKS_PER_SEC).
  - round_len[3:0]: latched copy of roundTime.
  - running flag.
- Idle (gameState=0):
  - Each edge forces prescaler=0, secs_left=0, running=0, cout=0.
  - gameState dropping mid-round aborts the round; no cout is produced.
- Start:
  - Condition: first edge with gameState=1 and running=0.
  - Actions: round_len<=roundTime, secs_left<=roundTime, prescaler<=0, running<=1, cout<=0.
  - If roundTime=0 at start: running stays 0 and secs_left=0. The start condition is re-evaluated every edge, so timing begins once roundTime becomes nonzero.
- Running (gameState=1, running=1):
  - prescaler increments each edge and wraps to 0 after TICKS_PER_SEC-1. The wrap edge is a "tick".
  - On a tick with secs_left>1: secs_left decrements.
  - On a tick with secs_left==1:
    - cout<=1 for exactly one cycle.
    - round_len<=roundTime and secs_left<=roundTime, i.e. the next round auto-starts using the current roundTime.
    - If that roundTime is 0: running<=0 and secs_left<=0, returning to the start condition.
  - On all other edges: cout<=0.
- Timing:
  - With start at edge E0, cout is high in the cycle following edge E0 + roundTime*TICKS_PER_SEC.
  - Subsequent pulses are spaced round_len*TICKS_PER_SEC cycles apart.
  - cout is never high on two consecutive cycles.
- roundTime changes mid-round do not affect the current round. They take effect only at the next start/reload.
- Arithmetic is unsigned; secs_left never underflows below 0.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Reset and enable: TICKS_PER_SEC=4, rst_n low then high, gameState=1, roundTime=5 from reset.
   - Expect cout=0 and secs_left=0 during reset.
   - Expect secs_left=5 after the start edge, decrementing every 4 cycles.
   - Expect the first cout pulse exactly 20 cycles after the start edge, lasting one cycle.
   - Expect repeat pulses every 20 cycles.
2. Idle hold: gameState=0 for 100 cycles.
   - Expect cout=0 and secs_left=0 throughout.
   - Then gameState=1 with roundTime=3: expect the first pulse 12 cycles after the start edge.
3. Abort: gameState drops after 10 cycles of a 5-second round.
   - Expect no cout and secs_left=0 next cycle.
   - Re-raise gameState: expect the count to restart from the full roundTime.
4. Mid-round change: roundTime changed 5->2 during a round.
   - Expect the current pulse at 20 cycles.
   - Expect following pulses every 8 cycles.
5. Zero length: roundTime=0 with gameState=1.
   - Expect cout=0 indefinitely.
   - Setting roundTime=1 starts timing: pulse 4 cycles after the start edge, then every 4 cycles.
6. Async reset: rst_n pulsed low between clock edges mid-round.
   - Expect outputs cleared immediately, without waiting for a clock edge.
   - After release, expect a full fresh round.
